// File: rtl/rr_arbiter_8.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter_8
//  Description : 8-way round-robin arbiter with bounded hold time, forced
//                revocation (timeout pulse) and a fixed two-cycle dead time
//                between owners. All outputs are registered; the one-hot
//                grant is a registered decode of the winning index.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter_8 #(
    parameter int MAX_HOLD = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req,
    output logic [7:0] gnt,
    output logic [2:0] gnt_idx,
    output logic       gnt_valid,
    output logic       timeout
);

    localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HW-1:0] C_HOLD_LAST = HW'(MAX_HOLD - 1);

    localparam logic [1:0] C_IDLE    = 2'd0;
    localparam logic [1:0] C_GRANT   = 2'd1;
    localparam logic [1:0] C_RELEASE = 2'd2;

    logic [1:0]    r_state;
    logic [1:0]    w_state_nxt;
    logic [7:0]    r_gnt;
    logic [2:0]    r_gnt_idx;
    logic          r_gnt_valid;
    logic          r_timeout;
    logic [HW-1:0] r_hold_cnt;
    logic [2:0]    r_last_idx;

    logic [2:0]    w_win_idx;
    logic [2:0]    w_cand;
    logic          w_any;
    logic          w_owner_req;
    logic          w_hold_done;
    logic [7:0]    w_gnt_nxt;
    logic [2:0]    w_gnt_idx_nxt;
    logic          w_gnt_valid_nxt;
    logic          w_timeout_nxt;
    logic [HW-1:0] w_hold_nxt;
    logic [2:0]    w_last_idx_nxt;

    assign w_owner_req = req[r_gnt_idx];
    assign w_hold_done = (r_hold_cnt == C_HOLD_LAST);

    // Rotating priority search: first set request after the last winner, wrapping 7 -> 0
    always_comb begin
        w_win_idx = r_last_idx;
        w_any     = 1'b0;
        w_cand    = r_last_idx;
        for (int k = 1; k <= 8; k++) begin
            w_cand = r_last_idx + 3'(k);
            if (!w_any && req[w_cand]) begin
                w_win_idx = w_cand;
                w_any     = 1'b1;
            end
        end
    end

    // State register and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= C_IDLE;
            r_gnt       <= 8'h00;
            r_gnt_idx   <= 3'd0;
            r_gnt_valid <= 1'b0;
            r_timeout   <= 1'b0;
            r_hold_cnt  <= '0;
            r_last_idx  <= 3'd7;
        end else begin
            r_state     <= w_state_nxt;
            r_gnt       <= w_gnt_nxt;
            r_gnt_idx   <= w_gnt_idx_nxt;
            r_gnt_valid <= w_gnt_valid_nxt;
            r_timeout   <= w_timeout_nxt;
            r_hold_cnt  <= w_hold_nxt;
            r_last_idx  <= w_last_idx_nxt;
        end
    end

    // Next-state logic: owner release or hold limit both end the grant
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            C_IDLE:    if (w_any) w_state_nxt = C_GRANT;
            C_GRANT:   if (!w_owner_req || w_hold_done) w_state_nxt = C_RELEASE;
            C_RELEASE: w_state_nxt = C_IDLE;
            default:   w_state_nxt = C_IDLE;
        endcase
    end

    // Next output values; a release coinciding with the hold limit is a normal release
    always_comb begin
        w_timeout_nxt   = (r_state == C_GRANT) && w_owner_req && w_hold_done;
        w_gnt_valid_nxt = (w_state_nxt == C_GRANT);
        w_gnt_idx_nxt   = r_gnt_idx;
        w_last_idx_nxt  = r_last_idx;
        if (r_state == C_IDLE && w_any) begin
            w_gnt_idx_nxt  = w_win_idx;
            w_last_idx_nxt = w_win_idx;
        end
        w_gnt_nxt  = w_gnt_valid_nxt ? (8'h01 << w_gnt_idx_nxt) : 8'h00;
        w_hold_nxt = (r_state == C_GRANT && w_state_nxt == C_GRANT) ?
                     r_hold_cnt + HW'(1) : '0;
    end

    assign gnt       = r_gnt;
    assign gnt_idx   = r_gnt_idx;
    assign gnt_valid = r_gnt_valid;
    assign timeout   = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_rr_arbiter_8.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rr_arbiter_8
//  Description : Scoreboard bench for rr_arbiter_8. A behavioural model
//                predicts the outputs after every clock edge and queues
//                them; an independent monitor pops and compares.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rr_arbiter_8;

    localparam int MAX_HOLD = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] req = 8'h00;
    logic [7:0] gnt;
    logic [2:0] gnt_idx;
    logic       gnt_valid;
    logic       timeout;

    rr_arbiter_8 #(.MAX_HOLD(MAX_HOLD)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] g;
        logic [2:0] i;
        logic       v;
        logic       t;
    } exp_t;

    exp_t q_exp[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    // Model state: owner (-1 = nobody), cycles held so far, pending dead cycles
    int   m_owner = -1;
    int   m_held  = 0;
    int   m_gap   = 0;
    int   m_last  = 7;
    int   m_idx   = 0;
    bit   m_tmo   = 1'b0;

    // Reference model: decides what the outputs must be after each edge
    always @(posedge clk) begin : model
        int   o, h, g, l, ix, c;
        bit   t, found;
        exp_t e;
        o = m_owner; h = m_held; g = m_gap; l = m_last; ix = m_idx; t = m_tmo;
        if (rst) begin
            o = -1; h = 0; g = 0; l = 7; ix = 0; t = 1'b0;
        end else if (o >= 0) begin
            h = h + 1;
            t = 1'b0;
            if (!req[o]) begin
                o = -1; g = 1;
            end else if (h == MAX_HOLD) begin
                o = -1; g = 1; t = 1'b1;
            end
        end else if (g > 0) begin
            g = 0; t = 1'b0;
        end else if (req != 8'h00) begin
            found = 1'b0;
            for (int k = 1; k <= 8; k++) begin
                c = (l + k) % 8;
                if (!found && req[c]) begin
                    o = c; found = 1'b1;
                end
            end
            l = o; ix = o; h = 0; t = 1'b0;
        end
        e.g = (o >= 0) ? (8'h01 << o) : 8'h00;
        e.i = 3'(ix);
        e.v = (o >= 0);
        e.t = t;
        q_exp.push_back(e);
        m_owner <= o; m_held <= h; m_gap <= g; m_last <= l; m_idx <= ix; m_tmo <= t;
    end

    // Monitor: compares the DUT outputs one time unit after each edge
    always @(posedge clk) begin : monitor
        exp_t e;
        #1;
        n_checks++;
        if (q_exp.size() == 0) begin
            $display("FAIL scoreboard-empty t=%0t actual gnt=%h but no expectation queued", $time, gnt);
        end else begin
            e = q_exp.pop_front();
            if (gnt === e.g && gnt_idx === e.i && gnt_valid === e.v && timeout === e.t)
                n_pass++;
            else
                $display("FAIL outputs t=%0t actual gnt=%h idx=%0d valid=%0b timeout=%0b required gnt=%h idx=%0d valid=%0b timeout=%0b",
                         $time, gnt, gnt_idx, gnt_valid, timeout, e.g, e.i, e.v, e.t);
        end
    end

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic reach(input bit ok, input string name);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL wait-%s actual not reached required reached within budget", name);
    endtask

    task automatic do_reset();
        rst = 1'b1; req = 8'h00;
        cyc(); cyc();
        rst = 1'b0;
    endtask

    initial begin
        int p;
        // Reset then single request, released after 5 grant cycles
        cyc(); cyc();
        rst = 1'b0;
        req = 8'h04;
        for (int i = 0; i < 20; i++) begin
            if (m_owner == 2 && m_held == 4) break;
            cyc();
        end
        reach(m_owner == 2 && m_held == 4, "single");
        req = 8'h00;
        repeat (4) cyc();

        // Rotation with all requesters, each releasing after 3 grant cycles
        do_reset();
        req = 8'hFF;
        repeat (50) begin
            cyc();
            if (m_owner >= 0 && m_held == 2) req = 8'hFF & ~(8'h01 << m_owner);
            else if (m_owner < 0 && m_gap == 1) req = 8'hFF;
        end

        // Timeout with a sole requester, then with two requesters
        do_reset();
        req = 8'h01;
        repeat (40) cyc();
        do_reset();
        req = 8'h03;
        repeat (40) cyc();

        // Release at the same edge the hold limit is reached
        do_reset();
        req = 8'h01;
        for (int i = 0; i < 30; i++) begin
            if (m_owner == 0 && m_held == MAX_HOLD - 1) break;
            cyc();
        end
        reach(m_owner == 0 && m_held == MAX_HOLD - 1, "simul");
        req = 8'h00;
        repeat (5) cyc();

        // Priority after owner 6 releases
        do_reset();
        req = 8'h40;
        for (int i = 0; i < 20; i++) begin
            if (m_owner == 6 && m_held == 1) break;
            cyc();
        end
        reach(m_owner == 6, "owner6");
        req = 8'h00;
        cyc();
        req = 8'h41;
        repeat (8) cyc();

        // Reset in the third cycle of a grant to index 5
        do_reset();
        req = 8'h20;
        for (int i = 0; i < 20; i++) begin
            if (m_owner == 5 && m_held == 2) break;
            cyc();
        end
        reach(m_owner == 5 && m_held == 2, "owner5");
        rst = 1'b1;
        req = 8'h21;
        cyc();
        rst = 1'b0;
        repeat (8) cyc();

        // Randomized traffic with varying request activity
        p = 30;
        for (int n = 0; n < 3000; n++) begin
            if (n % 200 == 0) p = ($urandom_range(0, 1) == 0) ? 2 : 30;
            if ($urandom_range(0, 99) < p) req = 8'($urandom);
            if (p > 2 && m_owner >= 0 && $urandom_range(0, 7) == 0) req[m_owner[2:0]] = 1'b0;
            rst = ($urandom_range(0, 299) == 0);
            cyc();
        end
        rst = 1'b0;
        cyc();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
